// File: rtl/mem_arbiter_2p.sv
// Two-core arbiter onto one single-port SRAM: same-cycle grant, round-robin on contention, 1-cycle response.
// No buffering; a losing core holds its request until it is granted.
module mem_arbiter_2p #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  port1_req_i,
   output logic                  port1_gnt_o,
   output logic                  port1_rvalid_o,
   input  logic [31:0]           port1_addr_i,
   input  logic                  port1_we_i,
   input  logic [3:0]            port1_be_i,
   input  logic [31:0]           port1_wdata_i,
   output logic [31:0]           port1_rdata_o,
   output logic                  port1_err_o,
   input  logic                  port2_req_i,
   output logic                  port2_gnt_o,
   output logic                  port2_rvalid_o,
   input  logic [31:0]           port2_addr_i,
   input  logic                  port2_we_i,
   input  logic [3:0]            port2_be_i,
   input  logic [31:0]           port2_wdata_i,
   output logic [31:0]           port2_rdata_o,
   output logic                  port2_err_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [31:0]           mem_wdata_o,
   input  logic [31:0]           mem_rdata_i,
   output logic [15:0]           conflict_cnt_o
);

   typedef struct packed {
      logic vld;
      logic port;   // 0 = port 1, 1 = port 2
      logic err;
      logic wr;
   } rsp_t;

   rsp_t        rsp_q;
   rsp_t        rsp_d;
   logic        prio_q;
   logic [15:0] cnt_q;

   logic        both_req;
   logic        gnt1;
   logic        gnt2;
   logic        any_gnt;
   logic        sel_port;
   logic [31:0] sel_addr;
   logic        sel_we;
   logic [3:0]  sel_be;
   logic [31:0] sel_wdata;
   logic        in_range;
   logic [31:0] rsp_data;
   logic        unused_addr_bits;

   // Grants are gated by reset so nothing reaches the SRAM while held in reset.
   always_comb begin
      both_req = port1_req_i & port2_req_i;
      gnt1     = rst_ni & port1_req_i & (~port2_req_i | ~prio_q);
      gnt2     = rst_ni & port2_req_i & (~port1_req_i | prio_q);
      any_gnt  = gnt1 | gnt2;
      sel_port = gnt2;
   end

   always_comb begin
      sel_addr  = port1_addr_i;
      sel_we    = port1_we_i;
      sel_be    = port1_be_i;
      sel_wdata = port1_wdata_i;
      if (sel_port) begin
         sel_addr  = port2_addr_i;
         sel_we    = port2_we_i;
         sel_be    = port2_be_i;
         sel_wdata = port2_wdata_i;
      end
   end

   assign in_range         = ((sel_addr >> (ADDR_WIDTH + 2)) == 32'd0);
   assign unused_addr_bits = ^{port1_addr_i[1:0], port2_addr_i[1:0]};

   always_comb begin
      mem_req_o   = any_gnt & in_range;
      mem_we_o    = any_gnt & in_range & sel_we;
      mem_addr_o  = sel_addr[ADDR_WIDTH+1:2];
      mem_be_o    = any_gnt ? sel_be : 4'b0000;
      mem_wdata_o = any_gnt ? sel_wdata : 32'd0;
   end

   assign port1_gnt_o = gnt1;
   assign port2_gnt_o = gnt2;

   always_comb begin
      rsp_d      = '0;
      rsp_d.vld  = any_gnt;
      rsp_d.port = sel_port;
      rsp_d.err  = any_gnt & ~in_range;
      rsp_d.wr   = any_gnt & sel_we;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_q  <= '0;
         prio_q <= 1'b0;
         cnt_q  <= 16'd0;
      end else begin
         rsp_q <= rsp_d;
         if (any_gnt) begin
            prio_q <= ~sel_port;
         end
         if (both_req && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   // SRAM data only belongs to an in-range read; writes and errors return zero.
   assign rsp_data = (rsp_q.vld && !rsp_q.err && !rsp_q.wr) ? mem_rdata_i : 32'd0;

   always_comb begin
      port1_rvalid_o = rsp_q.vld & ~rsp_q.port;
      port2_rvalid_o = rsp_q.vld & rsp_q.port;
      port1_rdata_o  = port1_rvalid_o ? rsp_data : 32'd0;
      port2_rdata_o  = port2_rvalid_o ? rsp_data : 32'd0;
      port1_err_o    = port1_rvalid_o & rsp_q.err;
      port2_err_o    = port2_rvalid_o & rsp_q.err;
   end

   assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p with a behavioural 1024x32 SRAM attached.
module tb_mem_arbiter_2p;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        port1_req_i, port1_gnt_o, port1_rvalid_o, port1_we_i, port1_err_o;
   logic [31:0] port1_addr_i, port1_wdata_i, port1_rdata_o;
   logic [3:0]  port1_be_i;
   logic        port2_req_i, port2_gnt_o, port2_rvalid_o, port2_we_i, port2_err_o;
   logic [31:0] port2_addr_i, port2_wdata_i, port2_rdata_o;
   logic [3:0]  port2_be_i;
   logic        mem_req_o, mem_we_o;
   logic [9:0]  mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic [15:0] conflict_cnt_o;

   logic [31:0] sram [0:1023];
   int          n_chk = 0;
   int          n_bad = 0;

   always #5 clk_i = ~clk_i;

   mem_arbiter_2p #(.ADDR_WIDTH(10)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .port1_req_i(port1_req_i), .port1_gnt_o(port1_gnt_o), .port1_rvalid_o(port1_rvalid_o),
      .port1_addr_i(port1_addr_i), .port1_we_i(port1_we_i), .port1_be_i(port1_be_i),
      .port1_wdata_i(port1_wdata_i), .port1_rdata_o(port1_rdata_o), .port1_err_o(port1_err_o),
      .port2_req_i(port2_req_i), .port2_gnt_o(port2_gnt_o), .port2_rvalid_o(port2_rvalid_o),
      .port2_addr_i(port2_addr_i), .port2_we_i(port2_we_i), .port2_be_i(port2_be_i),
      .port2_wdata_i(port2_wdata_i), .port2_rdata_o(port2_rdata_o), .port2_err_o(port2_err_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .conflict_cnt_o(conflict_cnt_o)
   );

   // Single-port SRAM: byte-masked write, read data one cycle after the strobe.
   always @(posedge clk_i) begin
      if (mem_req_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end else begin
            mem_rdata_i <= sram[mem_addr_o];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      port1_req_i = 0; port1_we_i = 0; port1_addr_i = 0; port1_be_i = 4'hF; port1_wdata_i = 0;
      port2_req_i = 0; port2_we_i = 0; port2_addr_i = 0; port2_be_i = 4'hF; port2_wdata_i = 0;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_ni = 0;
      step();
      step();
      rst_ni = 1;
      step();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) sram[i] = 32'd0;
      sram[4]     = 32'hDEADBEEF;
      sram[8]     = 32'hAABBCCDD;
      mem_rdata_i = 32'd0;
      idle();
      rst_ni      = 0;
      port1_req_i = 1;
      port2_req_i = 1;
      #2;
      chk("rst_gnt1", {31'd0, port1_gnt_o}, 32'd0);
      chk("rst_gnt2", {31'd0, port2_gnt_o}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      step();
      chk("rst_rvalid", {30'd0, port1_rvalid_o, port2_rvalid_o}, 32'd0);
      chk("rst_rdata1", port1_rdata_o, 32'd0);
      chk("rst_err", {30'd0, port1_err_o, port2_err_o}, 32'd0);
      chk("rst_cnt", {16'd0, conflict_cnt_o}, 32'd0);
      idle();
      rst_ni = 1;
      step();

      // Single port-1 read of word 4
      port1_req_i = 1; port1_addr_i = 32'h10;
      #1;
      chk("rd_gnt1", {31'd0, port1_gnt_o}, 32'd1);
      chk("rd_gnt2", {31'd0, port2_gnt_o}, 32'd0);
      chk("rd_mem_addr", {22'd0, mem_addr_o}, 32'd4);
      chk("rd_mem_req_we", {30'd0, mem_req_o, mem_we_o}, 32'b10);
      step();
      idle();
      #1;
      chk("rd_rvalid1", {31'd0, port1_rvalid_o}, 32'd1);
      chk("rd_rdata1", port1_rdata_o, 32'hDEADBEEF);
      chk("rd_err1", {31'd0, port1_err_o}, 32'd0);
      chk("rd_port2_quiet", {29'd0, port2_rvalid_o, port2_err_o, |port2_rdata_o}, 32'd0);

      // Continuous contention: alternating grants starting with port 1
      do_reset();
      port1_req_i = 1; port1_addr_i = 32'h10;
      port2_req_i = 1; port2_addr_i = 32'h20;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("alt_gnt_%0d", i), {30'd0, port1_gnt_o, port2_gnt_o},
             (i % 2 == 0) ? 32'b10 : 32'b01);
         chk($sformatf("alt_addr_%0d", i), {22'd0, mem_addr_o}, (i % 2 == 0) ? 32'd4 : 32'd8);
         if (i > 0)
            chk($sformatf("alt_rvalid_%0d", i), {30'd0, port1_rvalid_o, port2_rvalid_o},
                (i % 2 == 1) ? 32'b10 : 32'b01);
         step();
      end
      idle();
      #1;
      chk("alt_last_rvalid", {30'd0, port1_rvalid_o, port2_rvalid_o}, 32'b01);
      chk("alt_last_rdata2", port2_rdata_o, 32'hAABBCCDD);
      chk("alt_cnt", {16'd0, conflict_cnt_o}, 32'd4);

      // Port-2 partial write then read-back of the merged word
      step();
      port2_req_i = 1; port2_we_i = 1; port2_addr_i = 32'h20; port2_be_i = 4'b0011;
      port2_wdata_i = 32'h12345678;
      #1;
      chk("wr_gnt2", {31'd0, port2_gnt_o}, 32'd1);
      chk("wr_mem_we", {30'd0, mem_req_o, mem_we_o}, 32'b11);
      chk("wr_mem_addr", {22'd0, mem_addr_o}, 32'd8);
      chk("wr_mem_be", {28'd0, mem_be_o}, 32'b0011);
      chk("wr_mem_wdata", mem_wdata_o, 32'h12345678);
      step();
      idle();
      port2_req_i = 1; port2_addr_i = 32'h20;
      #1;
      chk("wr_rvalid", {30'd0, port1_rvalid_o, port2_rvalid_o}, 32'b01);
      chk("wr_rdata2", port2_rdata_o, 32'd0);
      chk("wr_err2", {31'd0, port2_err_o}, 32'd0);
      step();
      idle();
      #1;
      chk("wr_readback", port2_rdata_o, 32'hAABB5678);

      // Out-of-range accesses: granted, no SRAM strobe, error response
      step();
      port1_req_i = 1; port1_addr_i = 32'h1000;
      #1;
      chk("oor_gnt1", {31'd0, port1_gnt_o}, 32'd1);
      chk("oor_mem_req", {30'd0, mem_req_o, mem_we_o}, 32'd0);
      step();
      port1_we_i = 1; port1_addr_i = 32'h8000_0040; port1_wdata_i = 32'hFFFFFFFF;
      #1;
      chk("oor_rvalid1", {31'd0, port1_rvalid_o}, 32'd1);
      chk("oor_err1", {31'd0, port1_err_o}, 32'd1);
      chk("oor_rdata1", port1_rdata_o, 32'd0);
      chk("oor_wr_mem", {30'd0, mem_req_o, mem_we_o}, 32'd0);
      step();
      idle();
      #1;
      chk("oor_wr_err1", {31'd0, port1_err_o}, 32'd1);
      chk("oor_no_side_effect", sram[16], 32'd0);

      // Reset arriving right after a grant cancels its response
      step();
      port1_req_i = 1; port1_addr_i = 32'h10;
      #1;
      chk("rg_gnt1", {31'd0, port1_gnt_o}, 32'd1);
      rst_ni = 0;
      #1;
      chk("rg_gnt_in_rst", {30'd0, port1_gnt_o, port2_gnt_o}, 32'd0);
      step();
      chk("rg_no_rvalid", {30'd0, port1_rvalid_o, port2_rvalid_o}, 32'd0);
      step();
      rst_ni = 1;
      port2_req_i = 1; port2_addr_i = 32'h20;
      #1;
      chk("rg_cnt", {16'd0, conflict_cnt_o}, 32'd0);
      chk("rg_prio_port1", {30'd0, port1_gnt_o, port2_gnt_o}, 32'b10);

      // Counter saturation
      do_reset();
      port1_req_i = 1; port1_addr_i = 32'h10;
      port2_req_i = 1; port2_addr_i = 32'h20;
      repeat (65534) @(posedge clk_i);
      #1;
      chk("sat_fffe", {16'd0, conflict_cnt_o}, 32'hFFFE);
      repeat (3) @(posedge clk_i);
      #1;
      chk("sat_ffff", {16'd0, conflict_cnt_o}, 32'hFFFF);
      step();
      chk("sat_hold", {16'd0, conflict_cnt_o}, 32'hFFFF);
      idle();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
